// File: rtl/demux_collect4_1.sv
// Collects four skewed systolic result lanes and re-aligns them into whole rows.
// The rows are buffered in a small FIFO and sent out on a valid/ready stream with tile and error flags.
module demux_collect4_1 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int ROWS  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_valid,
    output logic [4*WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               tile_done,
    output logic               busy,
    output logic               overflow,
    output logic               skew_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    // Lane i is delayed by 3-i stages so that every lane lines up with lane 3.
    logic [2:0][WIDTH-1:0] l0_data;
    logic [2:0]            l0_valid;
    logic [1:0][WIDTH-1:0] l1_data;
    logic [1:0]            l1_valid;
    logic [WIDTH-1:0]      l2_data;
    logic                  l2_valid;
    logic [4*WIDTH-1:0]    al_data;
    logic [3:0]            al_valid;

    logic [4*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic [RW-1:0]      row_cnt;
    state_t             state;

    logic row_full;
    logic row_part;
    logic fifo_full;
    logic pop;
    logic push;

    always_comb begin
        row_full  = &al_valid;
        row_part  = (|al_valid) && !row_full;
        fifo_full = (count == CW'(DEPTH));
        pop       = out_valid && out_ready;
        // A full FIFO still accepts a row when the head leaves in the same cycle.
        push      = row_full && (!fifo_full || pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            l0_data  <= '0;
            l0_valid <= '0;
            l1_data  <= '0;
            l1_valid <= '0;
            l2_data  <= '0;
            l2_valid <= 1'b0;
            al_data  <= '0;
            al_valid <= '0;
        end else begin
            l0_data  <= {l0_data[1:0], in_data[0 +: WIDTH]};
            l0_valid <= {l0_valid[1:0], in_valid[0]};
            l1_data  <= {l1_data[0], in_data[WIDTH +: WIDTH]};
            l1_valid <= {l1_valid[0], in_valid[1]};
            l2_data  <= in_data[2*WIDTH +: WIDTH];
            l2_valid <= in_valid[2];
            al_data  <= {in_data[3*WIDTH +: WIDTH], l2_data, l1_data[1], l0_data[2]};
            al_valid <= {in_valid[3], l2_valid, l1_valid[1], l0_valid[2]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            row_cnt   <= '0;
            tile_done <= 1'b0;
            state     <= IDLE;
            overflow  <= 1'b0;
            skew_err  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            tile_done <= pop && (row_cnt == RW'(ROWS - 1));
            if (pop) row_cnt <= (row_cnt == RW'(ROWS - 1)) ? '0 : row_cnt + 1'b1;

            if (row_full && !push) overflow <= 1'b1;
            if (row_part)          skew_err <= 1'b1;

            // Leave STREAM only once the tile has drained and nothing is arriving.
            if (push)
                state <= STREAM;
            else if (state == STREAM && tile_done && count == '0 && al_valid == '0)
                state <= IDLE;
        end
    end

    // NOTE: row storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= al_data;
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign busy      = (state == STREAM);

endmodule

// File: tb/tb_demux_collect4_1.sv
// Bench for demux_collect4_1: scheduled stimulus, a row-level reference model and a
// scoreboard queue compared at every falling edge.
module tb_demux_collect4_1;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int ROWS  = 4;
    localparam int DW    = 4 * WIDTH;
    localparam int NS    = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [3:0]    in_valid = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          tile_done;
    logic          busy;
    logic          overflow;
    logic          skew_err;

    always #5 clk = ~clk;

    demux_collect4_1 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .tile_done(tile_done),
        .busy     (busy),
        .overflow (overflow),
        .skew_err (skew_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle stimulus schedule.
    logic [3:0]    s_valid [NS];
    logic [DW-1:0] s_data  [NS];
    bit            s_ready [NS];
    bit            s_rst   [NS];

    task automatic clear_sched(input bit ready);
        for (int i = 0; i < NS; i++) begin
            s_valid[i] = '0;
            s_data[i]  = {$urandom, $urandom};
            s_ready[i] = ready;
            s_rst[i]   = 1'b0;
        end
    endtask

    // Staggered row: lane i at start+i, optionally one lane a cycle late.
    task automatic add_row(input int start, input logic [WIDTH-1:0] base, input int late);
        for (int i = 0; i < 4; i++) begin
            int c = start + i + ((i == late) ? 1 : 0);
            if (c < NS) begin
                s_valid[c][i] = 1'b1;
                s_data[c][i*WIDTH +: WIDTH] = base + WIDTH'(i);
            end
        end
    endtask

    task automatic run_sched(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            in_valid  = s_valid[c];
            in_data   = s_data[c];
            out_ready = s_ready[c];
            rst_n     = !s_rst[c];
        end
    endtask

    task automatic do_reset();
        clear_sched(1'b0);
        s_rst[0] = 1'b1;
        s_rst[1] = 1'b1;
        run_sched(3);
        clear_sched(1'b1);
    endtask

    // Reference model: rows are formed from the input history, the FIFO is a queue.
    typedef struct {
        logic [3:0]    v;
        logic [DW-1:0] d;
    } in_t;

    in_t           hist[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf  = 1'b0;
    bit            m_skew = 1'b0;
    bit            m_tile = 1'b0;
    bit            m_busy = 1'b0;
    int            m_rc   = 0;
    int            pops_seen = 0;
    int            tile_seen = 0;

    always @(negedge clk) begin
        logic [3:0]    av;
        logic [DW-1:0] ad;
        bit            popped;
        bit            accept;
        int            occ;
        in_t           cur;

        check("out_valid", DW'(out_valid), DW'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
        else                   check("out_data_empty", out_data, '0);
        check("tile_done", DW'(tile_done), DW'(m_tile));
        check("busy", DW'(busy), DW'(m_busy));
        check("overflow", DW'(overflow), DW'(m_ovf));
        check("skew_err", DW'(skew_err), DW'(m_skew));
        if (tile_done === 1'b1) tile_seen++;

        if (!rst_n) begin
            hist.delete();
            exp_q.delete();
            m_ovf = 1'b0; m_skew = 1'b0; m_tile = 1'b0; m_busy = 1'b0; m_rc = 0;
        end else begin
            occ    = exp_q.size();
            popped = (occ != 0) && out_ready;
            if (popped) begin
                void'(exp_q.pop_front());
                pops_seen++;
            end
            // Lane i of the row completing now entered 4-i cycles ago.
            av = '0;
            ad = '0;
            for (int i = 0; i < 4; i++) begin
                if (hist.size() > 3 - i) begin
                    av[i] = hist[3-i].v[i];
                    ad[i*WIDTH +: WIDTH] = hist[3-i].d[i*WIDTH +: WIDTH];
                end
            end
            accept = (av == 4'hf) && (occ < DEPTH || popped);
            if (av == 4'hf && !accept) m_ovf = 1'b1;
            if (av != 4'h0 && av != 4'hf) m_skew = 1'b1;
            if (accept) exp_q.push_back(ad);
            if (accept) m_busy = 1'b1;
            else if (m_busy && m_tile && occ == 0 && av == 4'h0) m_busy = 1'b0;
            m_tile = popped && (m_rc == ROWS - 1);
            if (popped) m_rc = (m_rc + 1) % ROWS;
            cur.v = in_valid;
            cur.d = in_data;
            hist.push_front(cur);
            if (hist.size() > 4) void'(hist.pop_back());
        end
    end

    initial begin
        int p0;
        int t0;

        // Single row.
        do_reset();
        add_row(2, 16'h0010, -1);
        p0 = pops_seen;
        run_sched(14);
        check("single_pops", DW'(pops_seen - p0), DW'(1));

        // One full tile back to back.
        do_reset();
        for (int k = 0; k < 4; k++) add_row(2 + k, WIDTH'(16'h0100 + 16 * k), -1);
        p0 = pops_seen;
        t0 = tile_seen;
        run_sched(20);
        check("tile_pops", DW'(pops_seen - p0), DW'(4));
        check("tile_pulses", DW'(tile_seen - t0), DW'(1));
        check("tile_busy_end", DW'(busy), DW'(0));

        // Backpressure with overflow.
        do_reset();
        for (int k = 0; k < 6; k++) add_row(2 + k, WIDTH'(16'h0200 + 16 * k), -1);
        for (int c = 0; c < 16; c++) s_ready[c] = 1'b0;
        p0 = pops_seen;
        run_sched(30);
        check("bp_pops", DW'(pops_seen - p0), DW'(4));
        check("bp_overflow", DW'(overflow), DW'(1));

        // Full FIFO with a pop in the same cycle a fifth row arrives.
        do_reset();
        for (int k = 0; k < 4; k++) add_row(2 + k, WIDTH'(16'h0300 + 16 * k), -1);
        add_row(8, 16'h0340, -1);
        for (int c = 0; c < 20; c++) s_ready[c] = (c == 12);
        p0 = pops_seen;
        run_sched(30);
        check("fullpop_pops", DW'(pops_seen - p0), DW'(5));
        check("fullpop_overflow", DW'(overflow), DW'(0));

        // Lane 2 late, then a correct row.
        do_reset();
        add_row(2, 16'h0400, 2);
        add_row(10, 16'h0410, -1);
        p0 = pops_seen;
        run_sched(22);
        check("skew_pops", DW'(pops_seen - p0), DW'(1));
        check("skew_flag", DW'(skew_err), DW'(1));

        // Reset with two rows buffered and one in flight.
        do_reset();
        add_row(2, 16'h0500, -1);
        add_row(3, 16'h0510, -1);
        add_row(5, 16'h0520, -1);
        add_row(12, 16'h0530, -1);
        for (int c = 0; c < 12; c++) s_ready[c] = 1'b0;
        s_rst[8] = 1'b1;
        p0 = pops_seen;
        run_sched(24);
        check("rst_pops", DW'(pops_seen - p0), DW'(1));
        check("rst_skew", DW'(skew_err), DW'(0));

        // Randomized traffic, light then heavy backpressure.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 2) == 0)
                    add_row(c, WIDTH'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
                s_ready[c] = ($urandom_range(0, 9) < ((pass == 0) ? 7 : 3));
                if ($urandom_range(0, 29) == 0) s_valid[c][$urandom_range(0, 3)] = 1'b1;
            end
            for (int c = 400; c < 440; c++) s_ready[c] = 1'b1;
            run_sched(440);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
